// File: rtl/proc4.sv
// proc4: single-cycle RV32I subset core (addi, add, lw, sw, beq).
// Each instruction is fetched, decoded, executed and retired in one clock.
// Instruction memory (instance m3) and data memory (dmem) are internal and
// separate. The instruction memory has no write path from the core; its
// contents are loaded hierarchically through m3.mem.
//
// Ports:
//   w_clk    input  1  system clock, all state updates on the rising edge
//   w_rst_n  input  1  asynchronous active-low reset (clears r_pc and x1..x31)
//
// Observation nets: w_r1 (rs1 value), w_s2 (second ALU operand),
// w_rt (writeback value; effective address for sw).

module proc4_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] mem [0:WORDS-1];

  assign data = mem[addr];
endmodule

module proc4 #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input logic w_clk,
  input logic w_rst_n
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  logic [31:0]        r_pc;
  logic [31:0]        next_pc;
  logic [31:0]        inst;
  logic [31:0]        rf [1:31];
  logic [31:0]        dmem [0:DMEM_WORDS-1];

  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [2:0]         funct3;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [6:0]         funct7;

  logic               is_addi;
  logic               is_add;
  logic               is_lw;
  logic               is_sw;
  logic               is_beq;
  logic               reg_wr;
  logic               taken;

  logic signed [31:0] imm;
  logic signed [31:0] br_off;
  logic [31:0]        rs2_val;
  logic [31:0]        alu;
  logic [31:0]        load_data;
  logic [31:0]        w_r1;
  logic [31:0]        w_s2;
  logic [31:0]        w_rt;

  proc4_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) m3 (
    .addr (r_pc[IAW+1:2]),
    .data (inst)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Anything not matched exactly falls through as a NOP: no write, PC+4.
  assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'd0);
  assign is_add  = (opcode == OP_REG)    && (funct3 == 3'd0) && (funct7 == 7'd0);
  assign is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'd2);
  assign is_sw   = (opcode == OP_STORE)  && (funct3 == 3'd2);
  assign is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'd0);
  assign reg_wr  = is_addi || is_add || is_lw;

  // x0 is not stored; it always reads as zero.
  assign w_r1    = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  assign imm     = is_sw ? imm_s(inst) : imm_i(inst);
  assign br_off  = imm_b(inst);
  assign w_s2    = (is_add || is_beq) ? rs2_val : imm;
  assign alu     = w_r1 + w_s2;

  assign load_data = dmem[alu[DAW+1:2]];
  assign w_rt      = is_lw ? load_data : alu;

  assign taken   = is_beq && (w_r1 == rs2_val);
  assign next_pc = taken ? (r_pc + br_off) : (r_pc + 32'd4);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= next_pc;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 1; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (reg_wr && (rd != 5'd0)) begin
      rf[rd] <= w_rt;
    end
  end

  // Data memory keeps its contents across reset; stores are suppressed
  // while reset is held so the instruction parked at pc 0 cannot write.
  always_ff @(posedge w_clk) begin
    if (is_sw && w_rst_n) begin
      dmem[alu[DAW+1:2]] <= rs2_val;
    end
  end
endmodule

// File: tb/tb_proc4.sv
// tb_proc4: directed-program bench for proc4. A reference model executes the
// same program at the instruction level and is compared against the core on
// every cycle; literal expectations pin the model to hand-computed values.

module tb_proc4;
  logic w_clk;
  logic w_rst_n;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  logic [31:0] img [0:1023];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_pc;
  logic [31:0] m_dmem [int];

  proc4 #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dreg(input int i);
    if (i == 0) return 32'd0;
    return dut.rf[i];
  endfunction

  task automatic load_word(input int idx, input logic [31:0] w);
    img[idx] = w;
    dut.m3.mem[idx] = w;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 32'd0;
  endtask

  function automatic int sx(input logic [31:0] v, input int bits);
    int s;
    s = int'(v);
    s = s << (32 - bits);
    return s >>> (32 - bits);
  endfunction

  // Instruction-level semantics of the supported subset.
  task automatic model_eval(input logic [31:0] ins,
                            output bit known, output logic [31:0] r1,
                            output logic [31:0] s2, output logic [31:0] rt,
                            output bit wr, output int rdi,
                            output bit st, output logic [31:0] npc);
    int a, b, rd_n, f3, f7, op;
    logic [31:0] ld;
    op   = int'(ins & 32'h7f);
    rd_n = int'((ins >> 7) & 32'h1f);
    f3   = int'((ins >> 12) & 32'h7);
    f7   = int'(ins >> 25);
    a    = int'(m_reg[(ins >> 15) & 32'h1f]);
    b    = int'(m_reg[(ins >> 20) & 32'h1f]);
    known = 0; wr = 0; st = 0; rdi = rd_n;
    r1 = a; s2 = 0; rt = 0;
    npc = m_pc + 4;
    if (op == 'h13 && f3 == 0) begin
      known = 1; wr = 1; s2 = sx(ins >> 20, 12); rt = a + int'(s2);
    end else if (op == 'h33 && f3 == 0 && f7 == 0) begin
      known = 1; wr = 1; s2 = b; rt = a + b;
    end else if (op == 'h03 && f3 == 2) begin
      known = 1; wr = 1; s2 = sx(ins >> 20, 12);
      ld = 32'd0;
      if (m_dmem.exists(((a + int'(s2)) >>> 2) & 1023)) ld = m_dmem[((a + int'(s2)) >>> 2) & 1023];
      rt = ld;
    end else if (op == 'h23 && f3 == 2) begin
      known = 1; st = 1;
      s2 = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1f), 12);
      rt = a + int'(s2);
    end else if (op == 'h63 && f3 == 0) begin
      known = 1; s2 = b; rt = a + b;
      if (a == b)
        npc = m_pc + sx(((ins >> 31) << 12) | (((ins >> 7) & 1) << 11) |
                        (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1), 13);
    end
  endtask

  always @(posedge w_clk) begin
    bit kn, wr, st; int rdi;
    logic [31:0] r1, s2, rt, npc, ins;
    if (w_rst_n && chk_en) begin
      ins = img[(m_pc >> 2) % 1024];
      model_eval(ins, kn, r1, s2, rt, wr, rdi, st, npc);
      if (wr && rdi != 0) m_reg[rdi] = rt;
      if (st) m_dmem[int'(rt >> 2) & 1023] = m_reg[(ins >> 20) & 32'h1f];
      m_pc = npc;
    end
  end

  always @(negedge w_clk) begin
    bit kn, wr, st; int rdi;
    logic [31:0] r1, s2, rt, npc;
    if (w_rst_n && chk_en) begin
      chk("pc", dut.r_pc, m_pc);
      for (int i = 1; i < 32; i++) chk($sformatf("x%0d", i), dreg(i), m_reg[i]);
      model_eval(img[(m_pc >> 2) % 1024], kn, r1, s2, rt, wr, rdi, st, npc);
      if (kn) begin
        chk("w_r1", dut.w_r1, r1);
        chk("w_s2", dut.w_s2, s2);
        chk("w_rt", dut.w_rt, rt);
      end
    end
  end

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    w_rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) load_word(i, 32'h0000_0000);
    load_word(0, 32'h0070_0093);  // addi x1,x0,7
    load_word(1, 32'h0010_2423);  // sw   x1,8(x0)
    load_word(2, 32'h0080_2103);  // lw   x2,8(x0)
    load_word(3, 32'hFFF0_0193);  // addi x3,x0,-1
    load_word(4, 32'hFE00_8CE3);  // beq  x1,x0,-8 (not taken)
    load_word(5, 32'h0011_8233);  // add  x4,x3,x1
    load_word(6, 32'h0050_0013);  // addi x0,x0,5
    load_word(7, 32'h0000_0000);  // undefined -> NOP
    load_word(8, 32'hFE10_8CE3);  // beq  x1,x1,-8 (taken -> 0x18)
    repeat (2) @(posedge w_clk);
    @(negedge w_clk); #1;
    w_rst_n = 1'b1;
    chk_en  = 1;

    chk("c0_r1", dut.w_r1, 32'd0);
    chk("c0_s2", dut.w_s2, 32'd7);
    chk("c0_rt", dut.w_rt, 32'd7);
    step();
    chk("addi_x1", dreg(1), 32'd7);
    chk("pc_4", dut.r_pc, 32'h4);
    chk("sw_r1", dut.w_r1, 32'd0);
    chk("sw_s2", dut.w_s2, 32'd8);
    chk("sw_rt", dut.w_rt, 32'd8);
    step();
    chk("dmem2", dut.dmem[2], 32'd7);
    chk("lw_s2", dut.w_s2, 32'd8);
    chk("lw_rt", dut.w_rt, 32'd7);
    step();
    chk("lw_x2", dreg(2), 32'd7);
    step();
    chk("x3_neg1", dreg(3), 32'hFFFF_FFFF);
    chk("pc_10", dut.r_pc, 32'h10);
    step();
    chk("beq_nt_pc", dut.r_pc, 32'h14);
    step();
    chk("add_x4", dreg(4), 32'd6);
    step();
    chk("x0_pc", dut.r_pc, 32'h1C);
    step();
    chk("nop_pc", dut.r_pc, 32'h20);
    chk("nop_x4", dreg(4), 32'd6);
    step();
    chk("beq_t_pc", dut.r_pc, 32'h18);
    repeat (4) step();

    // Asynchronous reset in the middle of a cycle.
    @(posedge w_clk); #3;
    w_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", dut.r_pc, 32'd0);
    chk("rst_x1", dreg(1), 32'd0);
    chk("rst_x4", dreg(4), 32'd0);
    chk("rst_dmem", dut.dmem[2], 32'd7);
    repeat (2) @(posedge w_clk);

    for (int i = 0; i < 10; i++) load_word(i, 32'h0000_0000);
    load_word(0, 32'h0070_0093);  // addi x1,x0,7
    load_word(1, 32'h0080_2283);  // lw   x5,8(x0)
    load_word(4, 32'hFE10_8CE3);  // beq  x1,x1,-8 at 0x10 -> 0x08
    @(negedge w_clk); #1;
    w_rst_n = 1'b1;
    chk("b_c0_rt", dut.w_rt, 32'd7);
    step();
    chk("b_lw_rt", dut.w_rt, 32'd7);
    step();
    chk("b_x5", dreg(5), 32'd7);
    step();
    step();
    chk("b_pc_10", dut.r_pc, 32'h10);
    step();
    chk("b_beq_pc", dut.r_pc, 32'h08);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
